// File: rtl/barrel_shift_arbiter_if.sv
// rtl/barrel_shift_arbiter_if.sv - request, shifter and response bus bundle for barrel_shift_arbiter
interface barrel_shift_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = $clog2(NUM_ELEMENTS)
);
  localparam int BEAT_W = NUM_ELEMENTS * DATA_WIDTH;

  // Requester side: one beat lane per requester, flattened requester-major
  logic [NUM_REQ*BEAT_W-1:0]       req_data;
  logic [NUM_REQ*NUM_ELEMENTS-1:0] req_keep;
  logic [NUM_REQ*OFFSET_WIDTH-1:0] req_offset;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;

  // Issue toward the shared shifter
  logic [BEAT_W-1:0]               shf_data;
  logic [NUM_ELEMENTS-1:0]         shf_keep;
  logic [OFFSET_WIDTH-1:0]         shf_offset;
  logic                            shf_valid;

  // Results returning from the shifter
  logic [BEAT_W-1:0]               shf_res_data;
  logic [NUM_ELEMENTS-1:0]         shf_res_keep;
  logic                            shf_res_valid;

  // Per-requester responses
  logic [NUM_REQ*BEAT_W-1:0]       rsp_data;
  logic [NUM_REQ*NUM_ELEMENTS-1:0] rsp_keep;
  logic [NUM_REQ-1:0]              rsp_valid;
  logic [NUM_REQ-1:0]              rsp_ready;

  modport slave (
    input  req_data, req_keep, req_offset, req_valid,
    output req_ready,
    output shf_data, shf_keep, shf_offset, shf_valid,
    input  shf_res_data, shf_res_keep, shf_res_valid,
    output rsp_data, rsp_keep, rsp_valid,
    input  rsp_ready
  );

  modport master (
    output req_data, req_keep, req_offset, req_valid,
    input  req_ready,
    input  shf_data, shf_keep, shf_offset, shf_valid,
    output shf_res_data, shf_res_keep, shf_res_valid,
    input  rsp_data, rsp_keep, rsp_valid,
    output rsp_ready
  );
endinterface

// File: rtl/barrel_shift_arbiter.sv
// rtl/barrel_shift_arbiter.sv - round-robin sharing of one fixed-latency barrel shifter across requesters
module barrel_shift_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int LATENCY      = 2,
  parameter int RSP_DEPTH    = 4,
  parameter int OFFSET_WIDTH = $clog2(NUM_ELEMENTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  barrel_shift_arbiter_if.slave bus,
  output logic                  err_o
);
  localparam int BEAT_W = NUM_ELEMENTS * DATA_WIDTH;
  localparam int IDW    = $clog2(NUM_REQ);
  localparam int CW     = $clog2(RSP_DEPTH + 1);
  localparam int PW     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  // Arbitration state
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]           credit_q [NUM_REQ];
  logic [CW-1:0]           credit_d [NUM_REQ];
  logic [NUM_REQ-1:0]      elig;
  logic [NUM_REQ-1:0]      grant_oh;
  logic                    grant_vld;
  logic [IDW-1:0]          grant_id;
  logic [IDW-1:0]          cand;

  // Selected beat of the granted requester
  logic [BEAT_W-1:0]       sel_data;
  logic [NUM_ELEMENTS-1:0] sel_keep;
  logic [OFFSET_WIDTH-1:0] sel_offset;

  // Issue registers toward the shifter
  logic                    shf_valid_q;
  logic [BEAT_W-1:0]       shf_data_q;
  logic [NUM_ELEMENTS-1:0] shf_keep_q;
  logic [OFFSET_WIDTH-1:0] shf_offset_q;

  // Tag pipe: stage 0 lines up with shf_valid_q, stage LATENCY with the shifter result
  logic                    tag_vld_q [LATENCY+1];
  logic [IDW-1:0]          tag_id_q  [LATENCY+1];
  logic                    tag_out_vld;
  logic [IDW-1:0]          tag_out_id;
  logic                    wr_en;
  logic                    lost_any;
  logic                    mismatch;
  logic                    err_q;

  // Response FIFOs
  logic [BEAT_W-1:0]       fifo_data_q [NUM_REQ][RSP_DEPTH];
  logic [NUM_ELEMENTS-1:0] fifo_keep_q [NUM_REQ][RSP_DEPTH];
  logic [PW-1:0]           wr_ptr_q [NUM_REQ];
  logic [PW-1:0]           rd_ptr_q [NUM_REQ];
  logic [CW-1:0]           count_q  [NUM_REQ];
  logic [CW-1:0]           count_d  [NUM_REQ];
  logic [NUM_REQ-1:0]      wr_sel;
  logic [NUM_REQ-1:0]      pop;
  logic [NUM_REQ-1:0]      lost;
  logic [NUM_REQ-1:0]      rsp_vld;
  logic [NUM_REQ*BEAT_W-1:0]       rsp_data;
  logic [NUM_REQ*NUM_ELEMENTS-1:0] rsp_keep;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pick: first eligible requester after the last one granted.
  always_comb begin
    elig      = '0;
    grant_oh  = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_valid[i] && (credit_q[i] != '0);
    end
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    if (grant_vld) begin
      grant_oh[grant_id] = 1'b1;
      rr_ptr_d           = grant_id;
    end
  end

  // Grant is the ready; masked during reset so every output reads 0 while held.
  assign bus.req_ready = grant_oh & {NUM_REQ{rst_n_i}};

  // One-hot mux of the granted requester's beat.
  always_comb begin
    sel_data   = '0;
    sel_keep   = '0;
    sel_offset = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_data   = bus.req_data[i*BEAT_W +: BEAT_W];
        sel_keep   = bus.req_keep[i*NUM_ELEMENTS +: NUM_ELEMENTS];
        sel_offset = bus.req_offset[i*OFFSET_WIDTH +: OFFSET_WIDTH];
      end
    end
  end

  // Register the granted beat toward the shifter; the last beat is held while idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shf_valid_q  <= 1'b0;
      shf_data_q   <= '0;
      shf_keep_q   <= '0;
      shf_offset_q <= '0;
      rr_ptr_q     <= IDW'(NUM_REQ - 1);
    end else begin
      shf_valid_q <= grant_vld;
      rr_ptr_q    <= rr_ptr_d;
      if (grant_vld) begin
        shf_data_q   <= sel_data;
        shf_keep_q   <= sel_keep;
        shf_offset_q <= sel_offset;
      end
    end
  end

  assign bus.shf_valid  = shf_valid_q;
  assign bus.shf_data   = shf_data_q;
  assign bus.shf_keep   = shf_keep_q;
  assign bus.shf_offset = shf_offset_q;

  // Tag pipe advances every cycle because the shifter never stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s <= LATENCY; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_id_q[s]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= grant_vld;
      tag_id_q[0]  <= grant_id;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  assign tag_out_vld = tag_vld_q[LATENCY];
  assign tag_out_id  = tag_id_q[LATENCY];
  assign wr_en       = bus.shf_res_valid && tag_out_vld;
  assign mismatch    = bus.shf_res_valid != tag_out_vld;
  // A tagged beat whose result never showed up hands its credit back so the
  // requester cannot be locked out permanently; the error flag records it.
  assign lost_any    = tag_out_vld && !bus.shf_res_valid;

  // Per-requester FIFO bookkeeping and credit accounting.
  always_comb begin
    wr_sel   = '0;
    pop      = '0;
    lost     = '0;
    rsp_vld  = '0;
    rsp_data = '0;
    rsp_keep = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_sel[i]  = wr_en && (tag_out_id == IDW'(i));
      lost[i]    = lost_any && (tag_out_id == IDW'(i));
      rsp_vld[i] = count_q[i] != '0;
      pop[i]     = rsp_vld[i] && bus.rsp_ready[i];
      count_d[i]  = count_q[i] + CW'(wr_sel[i]) - CW'(pop[i]);
      credit_d[i] = credit_q[i] + CW'(pop[i]) + CW'(lost[i]) - CW'(grant_oh[i]);
      if (rsp_vld[i]) begin
        rsp_data[i*BEAT_W +: BEAT_W]             = fifo_data_q[i][rd_ptr_q[i]];
        rsp_keep[i*NUM_ELEMENTS +: NUM_ELEMENTS] = fifo_keep_q[i][rd_ptr_q[i]];
      end
    end
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_keep  = rsp_keep;

  // Pointers, occupancy, credits and the sticky error flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        credit_q[i] <= CW'(RSP_DEPTH);
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (wr_sel[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
        if (pop[i])    rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        count_q[i]  <= count_d[i];
        credit_q[i] <= credit_d[i];
      end
      if (mismatch) err_q <= 1'b1;
    end
  end

  // FIFO storage needs no reset: occupancy gates everything read from it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_sel[i]) begin
        fifo_data_q[i][wr_ptr_q[i]] <= bus.shf_res_data;
        fifo_keep_q[i][wr_ptr_q[i]] <= bus.shf_res_keep;
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb/tb_barrel_shift_arbiter.sv - scoreboard bench for barrel_shift_arbiter
module tb_barrel_shift_arbiter;
  localparam int NREQ  = 4;
  localparam int NE    = 8;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int OW    = 3;
  localparam int BW    = NE * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  logic inject = 1'b0;

  always #5 clk = ~clk;

  barrel_shift_arbiter_if #(.NUM_REQ(NREQ), .NUM_ELEMENTS(NE), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW)) bus ();

  barrel_shift_arbiter #(
    .NUM_REQ(NREQ), .NUM_ELEMENTS(NE), .DATA_WIDTH(DW),
    .LATENCY(LAT), .RSP_DEPTH(DEPTH), .OFFSET_WIDTH(OW)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus),
    .err_o(err)
  );

  // Requester stimulus
  logic [BW-1:0]   st_data [NREQ];
  logic [NE-1:0]   st_keep [NREQ];
  logic [OW-1:0]   st_off  [NREQ];
  logic [NREQ-1:0] st_valid = '0;
  logic [NREQ-1:0] st_rready = '1;

  always_comb begin
    bus.req_data   = '0;
    bus.req_keep   = '0;
    bus.req_offset = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i*BW +: BW]   = st_data[i];
      bus.req_keep[i*NE +: NE]   = st_keep[i];
      bus.req_offset[i*OW +: OW] = st_off[i];
    end
    bus.req_valid = st_valid;
    bus.rsp_ready = st_rready;
  end

  // Shifter model: out element j takes in element (j+offset) mod NE
  function automatic logic [BW-1:0] shift_data(input logic [BW-1:0] d, input logic [OW-1:0] off);
    logic [BW-1:0] r;
    r = '0;
    for (int j = 0; j < NE; j++) r[j*DW +: DW] = d[((j + int'(off)) % NE)*DW +: DW];
    return r;
  endfunction

  function automatic logic [NE-1:0] shift_keep(input logic [NE-1:0] k, input logic [OW-1:0] off);
    logic [NE-1:0] r;
    r = '0;
    for (int j = 0; j < NE; j++) r[j] = k[(j + int'(off)) % NE];
    return r;
  endfunction

  logic [BW-1:0]  pd [LAT];
  logic [NE-1:0]  pk [LAT];
  logic [LAT-1:0] pv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int s = 0; s < LAT; s++) begin
        pd[s] <= '0;
        pk[s] <= '0;
      end
    end else begin
      pv[0] <= bus.shf_valid;
      pd[0] <= shift_data(bus.shf_data, bus.shf_offset);
      pk[0] <= shift_keep(bus.shf_keep, bus.shf_offset);
      for (int s = 1; s < LAT; s++) begin
        pv[s] <= pv[s-1];
        pd[s] <= pd[s-1];
        pk[s] <= pk[s-1];
      end
    end
  end

  assign bus.shf_res_valid = pv[LAT-1] | inject;
  assign bus.shf_res_data  = pd[LAT-1];
  assign bus.shf_res_keep  = pk[LAT-1];

  // Scoreboard
  typedef struct {
    int            id;
    logic [BW-1:0] d;
    logic [NE-1:0] k;
  } exp_t;

  exp_t sb[$];
  bit   sb_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_ptr = NREQ - 1;
  int   sb_hit;
  exp_t sb_e;

  always @(negedge clk) begin
    if (sb_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb_e.id = i;
          sb_e.d  = shift_data(st_data[i], st_off[i]);
          sb_e.k  = shift_keep(st_keep[i], st_off[i]);
          sb.push_back(sb_e);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          sb_hit = -1;
          for (int k = 0; k < sb.size(); k++) if (sb_hit < 0 && sb[k].id == i) sb_hit = k;
          n_cmp++;
          if (sb_hit < 0) begin
            n_bad++;
            $display("FAIL sb_unexpected_rsp req%0d: got a response, required none outstanding", i);
          end else begin
            if (bus.rsp_data[i*BW +: BW] !== sb[sb_hit].d || bus.rsp_keep[i*NE +: NE] !== sb[sb_hit].k) begin
              n_bad++;
              $display("FAIL sb_rsp req%0d: got %h/%h required %h/%h", i,
                       bus.rsp_data[i*BW +: BW], bus.rsp_keep[i*NE +: NE], sb[sb_hit].d, sb[sb_hit].k);
            end
            sb.delete(sb_hit);
          end
        end
      end
    end
  end

  task automatic new_beat(input int i);
    for (int j = 0; j < NE; j++) st_data[i][j*DW +: DW] = $urandom();
    st_keep[i] = NE'($urandom());
    st_off[i]  = OW'($urandom());
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) begin
      st_data[i] = '0;
      st_keep[i] = '0;
      st_off[i]  = '0;
    end
    st_valid = '0;
    st_rready = '1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b required 0", bus.req_ready); end
    n_cmp++; if (bus.shf_valid !== 1'b0) begin n_bad++; $display("FAIL reset_shf_valid: got %b required 0", bus.shf_valid); end
    n_cmp++; if (bus.shf_data !== '0) begin n_bad++; $display("FAIL reset_shf_data: got %h required 0", bus.shf_data); end
    n_cmp++; if (bus.rsp_valid !== '0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data: got %h required 0", bus.rsp_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b required 0", err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_en = 1'b1;
    exp_ptr = NREQ - 1;
  endtask

  task automatic test_single();
    logic [BW-1:0] exp_d;
    for (int j = 0; j < NE; j++) begin
      st_data[0][j*DW +: DW] = DW'(j);
      exp_d[j*DW +: DW] = DW'((j + 3) % NE);
    end
    st_keep[0] = 8'hFF;
    st_off[0]  = 3'd3;
    st_valid   = 4'b0001;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b required 0001", bus.req_ready); end
    @(posedge clk); #1;
    st_valid = '0;
    exp_ptr = 0;
    @(negedge clk);
    n_cmp++; if (bus.shf_valid !== 1'b1) begin n_bad++; $display("FAIL single_shf_valid: got %b required 1", bus.shf_valid); end
    n_cmp++; if (bus.shf_offset !== 3'd3) begin n_bad++; $display("FAIL single_shf_offset: got %0d required 3", bus.shf_offset); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid[0] !== (c == 3)) begin
        n_bad++; $display("FAIL single_latency t+%0d: got rsp_valid %b required %b", c + 1, bus.rsp_valid[0], (c == 3));
      end
      if (c == 3) begin
        n_cmp++; if (bus.rsp_data[BW-1:0] !== exp_d) begin n_bad++; $display("FAIL single_data: got %h required %h", bus.rsp_data[BW-1:0], exp_d); end
        n_cmp++; if (bus.rsp_keep[NE-1:0] !== 8'hFF) begin n_bad++; $display("FAIL single_keep: got %h required ff", bus.rsp_keep[NE-1:0]); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int cnt [NREQ];
    logic [NREQ-1:0] gnt, exp_oh;
    int exp_g;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0;
      new_beat(i);
    end
    st_valid = '1;
    st_rready = '1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      gnt = bus.req_valid & bus.req_ready;
      exp_g = (exp_ptr + 1) % NREQ;
      exp_oh = '0;
      exp_oh[exp_g] = 1'b1;
      n_cmp++; if (gnt !== exp_oh) begin n_bad++; $display("FAIL rr_order cycle %0d: got %b required %b", c, gnt, exp_oh); end
      if (c > 0) begin
        n_cmp++; if (bus.shf_valid !== 1'b1) begin n_bad++; $display("FAIL rr_shf_valid cycle %0d: got 0 required 1", c); end
      end
      exp_ptr = exp_g;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) cnt[i]++;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) new_beat(i);
    end
    for (int i = 0; i < NREQ; i++) begin
      n_cmp++; if (cnt[i] != 100) begin n_bad++; $display("FAIL rr_share req%0d: got %0d grants required 100", i, cnt[i]); end
    end
    st_valid = '0;
    repeat (10) @(posedge clk); #1;
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rr_drain: got %0d outstanding required 0", sb.size()); end
  endtask

  task automatic test_stall();
    logic [NREQ-1:0] gnt, exp_oh, elig;
    int exp_g, a1, cnd;
    bit resumed;
    a1 = 0;
    for (int i = 0; i < NREQ; i++) new_beat(i);
    st_valid = '1;
    st_rready = 4'b1101;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      gnt = bus.req_valid & bus.req_ready;
      elig = '1;
      if (a1 >= DEPTH) elig[1] = 1'b0;
      exp_g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        cnd = (exp_ptr + k) % NREQ;
        if (exp_g < 0 && elig[cnd]) exp_g = cnd;
      end
      exp_oh = '0;
      exp_oh[exp_g] = 1'b1;
      n_cmp++; if (gnt !== exp_oh) begin n_bad++; $display("FAIL stall_order cycle %0d: got %b required %b", c, gnt, exp_oh); end
      exp_ptr = exp_g;
      if (gnt[1]) a1++;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) new_beat(i);
    end
    n_cmp++; if (a1 != DEPTH) begin n_bad++; $display("FAIL stall_req1_accepts: got %0d required %0d", a1, DEPTH); end
    st_rready = '1;
    resumed = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      gnt = bus.req_valid & bus.req_ready;
      if (gnt[1]) resumed = 1'b1;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) exp_ptr = i;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) new_beat(i);
    end
    n_cmp++; if (!resumed) begin n_bad++; $display("FAIL stall_resume: got no req1 grant in 20 cycles required one"); end
    st_valid = '0;
    repeat (12) @(posedge clk); #1;
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL stall_drain: got %0d outstanding required 0", sb.size()); end
  endtask

  task automatic test_credit();
    logic [NREQ-1:0] gnt;
    int a2;
    a2 = 0;
    new_beat(2);
    st_valid = 4'b0100;
    st_rready = 4'b1011;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      gnt = bus.req_valid & bus.req_ready;
      if (gnt[2]) begin a2++; exp_ptr = 2; end
      @(posedge clk); #1;
      if (gnt[2]) new_beat(2);
    end
    @(negedge clk);
    n_cmp++; if (a2 != DEPTH) begin n_bad++; $display("FAIL credit_fill: got %0d accepts required %0d", a2, DEPTH); end
    n_cmp++; if (bus.rsp_valid[2] !== 1'b1) begin n_bad++; $display("FAIL credit_fifo_full: got rsp_valid %b required 1", bus.rsp_valid[2]); end
    n_cmp++; if (bus.req_ready[2] !== 1'b0) begin n_bad++; $display("FAIL credit_zero_blocks: got %b required 0", bus.req_ready[2]); end
    @(posedge clk); #1;
    st_rready[2] = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready[2] !== 1'b0) begin n_bad++; $display("FAIL credit_pop_cycle: got %b required 0", bus.req_ready[2]); end
    @(posedge clk); #1;
    st_rready[2] = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready[2] !== 1'b1) begin n_bad++; $display("FAIL credit_returned: got %b required 1", bus.req_ready[2]); end
    @(posedge clk); #1;
    new_beat(2);
    @(negedge clk);
    n_cmp++; if (bus.req_ready[2] !== 1'b0) begin n_bad++; $display("FAIL credit_back_to_zero: got %b required 0", bus.req_ready[2]); end
    repeat (6) @(negedge clk);
    n_cmp++; if (bus.rsp_valid[2] !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL credit_refill: got rsp_valid %b err %b required 1 0", bus.rsp_valid[2], err);
    end
    @(posedge clk); #1;
    st_valid = '0;
    st_rready = '1;
    repeat (12) @(posedge clk); #1;
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL credit_drain: got %0d outstanding required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] gnt;
    int a0;
    for (int i = 0; i < NREQ; i++) new_beat(i);
    st_valid = '1;
    st_rready = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      gnt = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) new_beat(i);
    end
    rst_n = 1'b0;
    sb_en = 1'b0;
    sb.delete();
    #1;
    n_cmp++; if (bus.req_ready !== '0) begin n_bad++; $display("FAIL rstmid_req_ready: got %b required 0", bus.req_ready); end
    n_cmp++; if (bus.shf_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_shf_valid: got %b required 0", bus.shf_valid); end
    n_cmp++; if (bus.rsp_valid !== '0) begin n_bad++; $display("FAIL rstmid_rsp_valid: got %b required 0", bus.rsp_valid); end
    n_cmp++; if (bus.shf_data !== '0) begin n_bad++; $display("FAIL rstmid_shf_data: got %h required 0", bus.shf_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_en = 1'b1;
    @(negedge clk);
    gnt = bus.req_valid & bus.req_ready;
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rstmid_first_grant: got %b required 0001", gnt); end
    a0 = gnt[0] ? 1 : 0;
    @(posedge clk); #1;
    new_beat(0);
    st_valid = 4'b0001;
    st_rready = 4'b1110;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      gnt = bus.req_valid & bus.req_ready;
      if (gnt[0]) a0++;
      @(posedge clk); #1;
      if (gnt[0]) new_beat(0);
    end
    exp_ptr = 0;
    n_cmp++; if (a0 != DEPTH) begin n_bad++; $display("FAIL rstmid_credits: got %0d accepts required %0d", a0, DEPTH); end
    st_valid = '0;
    st_rready = '1;
    repeat (12) @(posedge clk); #1;
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rstmid_drain: got %0d outstanding required 0", sb.size()); end
  endtask

  task automatic test_err();
    st_valid = '0;
    st_rready = '1;
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pre: got %b required 0", err); end
    @(posedge clk); #1;
    inject = 1'b1;
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_same_cycle: got %b required 0", err); end
    @(posedge clk); #1;
    inject = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky cycle %0d: got %b required 1", c, err); end
      n_cmp++; if (bus.rsp_valid !== '0) begin n_bad++; $display("FAIL err_no_rsp cycle %0d: got %b required 0", c, bus.rsp_valid); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_credit();
    test_reset_mid();
    test_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
